// File: rtl/commit_shadow_stack_pkg.sv
// Shared types and helpers for the commit-side shadow stack checker.
package commit_shadow_stack_pkg;

  localparam int unsigned XLEN         = 64;
  localparam int unsigned DEFAULT_VLEN = 39;

  // Violation code carried in tval[1:0] of the control-flow exception.
  typedef enum logic [1:0] {
    CFI_NONE      = 2'd0,
    CFI_MISMATCH  = 2'd1,
    CFI_UNDERFLOW = 2'd2,
    CFI_OVERFLOW  = 2'd3
  } cfi_violation_e;

  // Custom exception cause used for every shadow stack violation.
  localparam logic [XLEN-1:0] CFI_EXC_CAUSE = 64'd24;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  // x1 (ra) and x5 (t0) are the RISC-V link registers; the commit stage uses
  // this to derive the call/return flags fed into the checker.
  function automatic logic is_link_reg(input logic [4:0] reg_idx);
    return (reg_idx == 5'd1) || (reg_idx == 5'd5);
  endfunction

  // tval layout: violation code in the two low bits, the zero-extended
  // offending target shifted above it.
  function automatic logic [XLEN-1:0] cfi_tval(input logic [XLEN-1:0] target,
                                               input cfi_violation_e code);
    return {target[XLEN-3:0], code};
  endfunction

endpackage

// File: rtl/shadow_stack_ram.sv
// Return-address storage: DEPTH x VLEN array with several write ports and
// asynchronous read ports. Writes within one cycle are applied in port order,
// so a higher port to the same address wins.
module shadow_stack_ram #(
  parameter int unsigned NR_PORTS = 2,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned VLEN     = 39,
  parameter int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                          i_clk,
  input  logic [NR_PORTS-1:0]           i_we,
  input  logic [NR_PORTS-1:0][AW-1:0]   i_waddr,
  input  logic [NR_PORTS-1:0][VLEN-1:0] i_wdata,
  input  logic [NR_PORTS-1:0][AW-1:0]   i_raddr,
  output logic [NR_PORTS-1:0][VLEN-1:0] o_rdata
);

  logic [VLEN-1:0] r_mem [DEPTH];

  // Apply this cycle's pushes in ascending port order.
  always_ff @(posedge i_clk) begin
    for (int p = 0; p < int'(NR_PORTS); p++) begin
      if (i_we[p]) begin
        r_mem[i_waddr[p]] <= i_wdata[p];
      end
    end
  end

  // Read ports return the contents as of the start of the cycle; anything
  // written earlier in the same cycle is forwarded by the caller.
  for (genvar gi = 0; gi < int'(NR_PORTS); gi++) begin : g_rd
    assign o_rdata[gi] = r_mem[i_raddr[gi]];
  end

endmodule

// File: rtl/commit_shadow_stack.sv
// Commit-side shadow stack: pushes link addresses on committed calls, pops and
// checks on committed returns, and raises a sticky control-flow exception on
// mismatch, underflow or overflow.
module commit_shadow_stack
  import commit_shadow_stack_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS   = 2,
  parameter int unsigned DEPTH             = 16,
  parameter int unsigned VLEN              = DEFAULT_VLEN,
  parameter bit          WRAP_ON_OVERFLOW  = 1'b0,
  parameter bit          TRAP_ON_UNDERFLOW = 1'b1,
  parameter int unsigned PW = (NR_COMMIT_PORTS > 1) ? $clog2(NR_COMMIT_PORTS) : 1,
  parameter int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 en_i,
  input  logic                                 clear_i,
  input  logic                                 ex_ack_i,
  input  logic [NR_COMMIT_PORTS-1:0]           commit_ack_i,
  input  logic [NR_COMMIT_PORTS-1:0][VLEN-1:0] commit_pc_i,
  input  logic [NR_COMMIT_PORTS-1:0]           commit_is_call_i,
  input  logic [NR_COMMIT_PORTS-1:0]           commit_is_ret_i,
  input  logic [NR_COMMIT_PORTS-1:0]           commit_is_compressed_i,
  input  logic [NR_COMMIT_PORTS-1:0][VLEN-1:0] commit_target_i,
  output exception_t                           exception_o,
  output logic [PW-1:0]                        violation_port_o,
  output logic [CW-1:0]                        depth_o
);

  localparam int unsigned    NR       = NR_COMMIT_PORTS;
  localparam int unsigned    AW       = $clog2(DEPTH);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  // Architectural state: tp is the next free slot, cnt the occupancy.
  logic [AW-1:0]  r_tp;
  logic [CW-1:0]  r_cnt;
  exception_t     r_exc;
  logic [PW-1:0]  r_viol_port;

  // Chain results for this cycle.
  logic [AW-1:0]          w_tp_next;
  logic [CW-1:0]          w_cnt_next;
  cfi_violation_e         w_viol;
  logic [PW-1:0]          w_viol_port;
  logic [VLEN-1:0]        w_viol_target;
  logic [NR-1:0]          w_active;

  // RAM interface.
  logic [NR-1:0]           w_we;
  logic [NR-1:0][AW-1:0]   w_waddr;
  logic [NR-1:0][VLEN-1:0] w_wdata;
  logic [NR-1:0][AW-1:0]   w_rd_addr;
  logic [NR-1:0][VLEN-1:0] w_rd_data;

  // A port only acts while checking is enabled, nothing is pending and no
  // clear/reset overrides the cycle.
  assign w_active = commit_ack_i
                  & {NR{en_i && !r_exc.valid && !clear_i && !rst_i}};

  // Pops can only reach entries that existed at the start of the cycle
  // through the N slots just below tp; slots pushed this cycle are forwarded
  // inside the chain. So the read addresses depend only on r_tp, which keeps
  // the RAM read path free of any dependency on the chain itself.
  for (genvar gi = 0; gi < int'(NR); gi++) begin : g_rd_addr
    assign w_rd_addr[gi] = r_tp - AW'(gi + 1);
  end

  shadow_stack_ram #(
    .NR_PORTS (NR),
    .DEPTH    (DEPTH),
    .VLEN     (VLEN),
    .AW       (AW)
  ) u_ram (
    .i_clk   (clk_i),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  // Walk ports 0..N-1 in order; each sees the tp/cnt left by the lower ports
  // and the chain stops at the first violation.
  always_comb begin : chain
    logic [AW-1:0]           v_tp;
    logic [CW-1:0]           v_cnt;
    logic                    v_halt;
    logic [VLEN-1:0]         v_link;
    logic [VLEN-1:0]         v_top;
    logic [NR-1:0]           v_we;
    logic [NR-1:0][AW-1:0]   v_waddr;
    logic [NR-1:0][VLEN-1:0] v_wdata;

    v_tp          = r_tp;
    v_cnt         = r_cnt;
    v_halt        = 1'b0;
    v_link        = '0;
    v_top         = '0;
    v_we          = '0;
    v_waddr       = '0;
    v_wdata       = '0;
    w_viol        = CFI_NONE;
    w_viol_port   = '0;
    w_viol_target = '0;

    for (int i = 0; i < int'(NR); i++) begin
      v_link = commit_pc_i[i]
             + (commit_is_compressed_i[i] ? VLEN'(2) : VLEN'(4));
      v_top  = '0;

      if (w_active[i] && !v_halt) begin
        // Pop-and-compare comes first so a coroutine swap checks the old
        // return address before pushing the new link.
        if (commit_is_ret_i[i]) begin
          if (v_cnt == '0) begin
            if (TRAP_ON_UNDERFLOW) begin
              v_halt = 1'b1;
              w_viol = CFI_UNDERFLOW;
            end
          end else begin
            v_tp  = v_tp - 1'b1;
            v_cnt = v_cnt - 1'b1;
            for (int k = 0; k < int'(NR); k++) begin
              if (w_rd_addr[k] == v_tp) begin
                v_top = w_rd_data[k];
              end
            end
            // Later lower-port writes override both the RAM and earlier ones.
            for (int j = 0; j < int'(NR); j++) begin
              if (v_we[j] && (v_waddr[j] == v_tp)) begin
                v_top = v_wdata[j];
              end
            end
            // The pop stands even when the comparison fails.
            if (v_top != commit_target_i[i]) begin
              v_halt = 1'b1;
              w_viol = CFI_MISMATCH;
            end
          end
        end

        if (commit_is_call_i[i] && !v_halt) begin
          if (v_cnt == FULL_CNT) begin
            if (WRAP_ON_OVERFLOW) begin
              // When full, the slot at tp holds the oldest entry.
              v_we[i]    = 1'b1;
              v_waddr[i] = v_tp;
              v_wdata[i] = v_link;
              v_tp       = v_tp + 1'b1;
            end else begin
              v_halt = 1'b1;
              w_viol = CFI_OVERFLOW;
            end
          end else begin
            v_we[i]    = 1'b1;
            v_waddr[i] = v_tp;
            v_wdata[i] = v_link;
            v_tp       = v_tp + 1'b1;
            v_cnt      = v_cnt + 1'b1;
          end
        end

        // Only the port that tripped the halt reaches here with it set.
        if (v_halt) begin
          w_viol_port   = PW'(i);
          w_viol_target = commit_target_i[i];
        end
      end
    end

    w_tp_next  = v_tp;
    w_cnt_next = v_cnt;
    w_we       = v_we;
    w_waddr    = v_waddr;
    w_wdata    = v_wdata;
  end

  // Commit the chain result and manage the sticky exception.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tp        <= '0;
      r_cnt       <= '0;
      r_exc       <= '0;
      r_viol_port <= '0;
    end else if (clear_i) begin
      r_tp        <= '0;
      r_cnt       <= '0;
      r_exc       <= '0;
      r_viol_port <= '0;
    end else begin
      r_tp  <= w_tp_next;
      r_cnt <= w_cnt_next;
      if (ex_ack_i) begin
        r_exc       <= '0;
        r_viol_port <= '0;
      end else if (w_viol != CFI_NONE) begin
        r_exc.valid <= 1'b1;
        r_exc.cause <= CFI_EXC_CAUSE;
        r_exc.tval  <= cfi_tval(XLEN'(w_viol_target), w_viol);
        r_viol_port <= w_viol_port;
      end
    end
  end

  assign exception_o      = r_exc;
  assign violation_port_o = r_viol_port;
  assign depth_o          = r_cnt;

endmodule

// File: tb/tb_commit_shadow_stack.sv
// Randomised bench for commit_shadow_stack. Two instances share stimulus:
// one traps on overflow/underflow, the other wraps and ignores underflow.
module tb_commit_shadow_stack;
  import commit_shadow_stack_pkg::*;

  localparam int NR    = 2;
  localparam int DEPTH = 16;
  localparam int VLEN  = 39;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst, en, clr, ex_ack;
  logic [NR-1:0]           ack, is_call, is_ret, is_comp;
  logic [NR-1:0][VLEN-1:0] pc, tgt;

  exception_t exc0, exc1;
  logic [0:0] vp0, vp1;
  logic [4:0] dep0, dep1;

  commit_shadow_stack #(
    .NR_COMMIT_PORTS(NR), .DEPTH(DEPTH), .VLEN(VLEN),
    .WRAP_ON_OVERFLOW(1'b0), .TRAP_ON_UNDERFLOW(1'b1)
  ) u_dut_trap (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clr), .ex_ack_i(ex_ack),
    .commit_ack_i(ack), .commit_pc_i(pc), .commit_is_call_i(is_call),
    .commit_is_ret_i(is_ret), .commit_is_compressed_i(is_comp),
    .commit_target_i(tgt), .exception_o(exc0), .violation_port_o(vp0),
    .depth_o(dep0)
  );

  commit_shadow_stack #(
    .NR_COMMIT_PORTS(NR), .DEPTH(DEPTH), .VLEN(VLEN),
    .WRAP_ON_OVERFLOW(1'b1), .TRAP_ON_UNDERFLOW(1'b0)
  ) u_dut_wrap (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clr), .ex_ack_i(ex_ack),
    .commit_ack_i(ack), .commit_pc_i(pc), .commit_is_call_i(is_call),
    .commit_is_ret_i(is_ret), .commit_is_compressed_i(is_comp),
    .commit_target_i(tgt), .exception_o(exc1), .violation_port_o(vp1),
    .depth_o(dep1)
  );

  // Reference model: plain bottom-up stack array per instance.
  logic [VLEN-1:0] m_stk [2][DEPTH];
  int              m_cnt [2];
  bit              m_pend[2];
  logic [63:0]     m_tval[2];
  int              m_vport[2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input int k);
    bit              wrap, trap, halt;
    int              viol, vport;
    logic [VLEN-1:0] vtgt, link, top;
    wrap = (k == 1);
    trap = (k == 0);
    if (rst || clr) begin
      m_cnt[k] = 0; m_pend[k] = 0; m_tval[k] = 0; m_vport[k] = 0;
      return;
    end
    halt = 0; viol = 0; vport = 0; vtgt = '0;
    if (en && !m_pend[k]) begin
      for (int p = 0; p < NR; p++) begin
        if (!halt && ack[p]) begin
          link = pc[p] + (is_comp[p] ? VLEN'(2) : VLEN'(4));
          if (is_ret[p]) begin
            if (m_cnt[k] == 0) begin
              if (trap) begin halt = 1; viol = 2; end
            end else begin
              m_cnt[k]--;
              top = m_stk[k][m_cnt[k]];
              if (top !== tgt[p]) begin halt = 1; viol = 1; end
            end
          end
          if (is_call[p] && !halt) begin
            if (m_cnt[k] == DEPTH) begin
              if (wrap) begin
                for (int s = 0; s < DEPTH - 1; s++) m_stk[k][s] = m_stk[k][s+1];
                m_stk[k][DEPTH-1] = link;
              end else begin
                halt = 1; viol = 3;
              end
            end else begin
              m_stk[k][m_cnt[k]] = link;
              m_cnt[k]++;
            end
          end
          if (halt) begin vport = p; vtgt = tgt[p]; end
        end
      end
    end
    if (ex_ack) begin
      m_pend[k] = 0; m_tval[k] = 0; m_vport[k] = 0;
    end else if (viol != 0) begin
      m_pend[k]  = 1;
      m_tval[k]  = (64'(vtgt) << 2) | 64'(viol);
      m_vport[k] = vport;
    end
  endtask

  task automatic compare_all();
    check_eq("depth0", 64'(dep0), 64'(m_cnt[0]));
    check_eq("valid0", 64'(exc0.valid), 64'(m_pend[0]));
    check_eq("cause0", exc0.cause, m_pend[0] ? 64'd24 : 64'd0);
    check_eq("tval0", exc0.tval, m_tval[0]);
    check_eq("vport0", 64'(vp0), 64'(m_vport[0]));
    check_eq("depth1", 64'(dep1), 64'(m_cnt[1]));
    check_eq("valid1", 64'(exc1.valid), 64'(m_pend[1]));
    check_eq("cause1", exc1.cause, m_pend[1] ? 64'd24 : 64'd0);
    check_eq("tval1", exc1.tval, m_tval[1]);
    check_eq("vport1", 64'(vp1), 64'(m_vport[1]));
  endtask

  task automatic idle();
    rst = 0; clr = 0; ex_ack = 0;
    ack = '0; is_call = '0; is_ret = '0; is_comp = '0; pc = '0; tgt = '0;
  endtask

  task automatic set_port(input int p, input logic c, input logic r,
                          input logic [VLEN-1:0] a, input logic cm,
                          input logic [VLEN-1:0] t);
    ack[p] = 1'b1; is_call[p] = c; is_ret[p] = r;
    pc[p] = a; is_comp[p] = cm; tgt[p] = t;
  endtask

  // One clock: model first (pre-edge inputs), then sample after the edge.
  task automatic step();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    compare_all();
    idle();
  endtask

  initial begin
    logic [63:0]     rr;
    logic [VLEN-1:0] pred;
    int              kind;
    bit              call_heavy;

    idle();
    en = 1'b0;
    rst = 1; step();
    rst = 1; step();
    check_eq("rst_depth", 64'(dep0), 64'd0);
    check_eq("rst_valid", 64'(exc0.valid), 64'd0);
    en = 1'b1;

    // Call then matching return on the next cycle.
    set_port(0, 1, 0, 39'h8000_0000, 0, '0); step();
    check_eq("t1_depth_call", 64'(dep0), 64'd1);
    set_port(0, 0, 1, '0, 0, 39'h8000_0004); step();
    check_eq("t1_depth_ret", 64'(dep0), 64'd0);
    check_eq("t1_valid", 64'(exc0.valid), 64'd0);

    // Same-cycle compressed call on port 0 and return on port 1.
    set_port(0, 1, 0, 39'h100, 1, '0);
    set_port(1, 0, 1, '0, 0, 39'h102); step();
    check_eq("t2_depth", 64'(dep0), 64'd0);
    check_eq("t2_valid", 64'(exc0.valid), 64'd0);

    // Mismatch, frozen stack while pending, then acknowledge.
    set_port(0, 1, 0, 39'h200, 0, '0); step();
    set_port(0, 0, 1, '0, 0, 39'h300); step();
    check_eq("t3_valid", 64'(exc0.valid), 64'd1);
    check_eq("t3_cause", exc0.cause, 64'd24);
    check_eq("t3_code", 64'(exc0.tval[1:0]), 64'(CFI_MISMATCH));
    check_eq("t3_tgt", exc0.tval >> 2, 64'h300);
    check_eq("t3_port", 64'(vp0), 64'd0);
    set_port(0, 1, 0, 39'h400, 0, '0); step();
    check_eq("t3_frozen", 64'(dep0), 64'd0);
    ex_ack = 1; step();
    check_eq("t3_acked", 64'(exc0.valid), 64'd0);

    // Return on empty stack.
    set_port(0, 0, 1, '0, 0, 39'h500); step();
    check_eq("t4_uflow", 64'(exc0.tval[1:0]), 64'(CFI_UNDERFLOW));
    check_eq("t4_nouflow", 64'(exc1.valid), 64'd0);
    check_eq("t4_depth", 64'(dep1), 64'd0);
    ex_ack = 1; step();

    // Seventeen calls, then sixteen returns on the wrapping instance.
    clr = 1; step();
    for (int c = 1; c <= 17; c++) begin
      set_port(0, 1, 0, VLEN'(32'h1000 + c * 16), 0, '0); step();
    end
    check_eq("t5_oflow", 64'(exc0.tval[1:0]), 64'(CFI_OVERFLOW));
    check_eq("t5_depth_trap", 64'(dep0), 64'd16);
    check_eq("t5_wrap_valid", 64'(exc1.valid), 64'd0);
    check_eq("t5_depth_wrap", 64'(dep1), 64'd16);
    ex_ack = 1; step();
    for (int r = 17; r >= 2; r--) begin
      set_port(0, 0, 1, '0, 0, VLEN'(32'h1000 + r * 16 + 4)); step();
      check_eq("t5_ret_ok", 64'(exc1.valid), 64'd0);
    end
    check_eq("t5_empty", 64'(dep1), 64'd0);

    // Violation on port 0 suppresses port 1; clear wins over a call; reset.
    ex_ack = 1; clr = 1; step();
    set_port(0, 0, 1, '0, 0, 39'h600);
    set_port(1, 1, 0, 39'h700, 0, '0); step();
    check_eq("t6_suppress", 64'(dep0), 64'd0);
    check_eq("t6_port", 64'(vp0), 64'd0);
    clr = 1; set_port(0, 1, 0, 39'h800, 0, '0); step();
    check_eq("t6_clr_depth", 64'(dep0), 64'd0);
    check_eq("t6_clr_valid", 64'(exc0.valid), 64'd0);
    for (int c = 0; c < 3; c++) begin
      set_port(0, 1, 0, VLEN'(32'h900 + c * 8), 0, '0); step();
    end
    rst = 1; set_port(0, 0, 1, '0, 0, 39'h1); step();
    check_eq("t6_rst_depth", 64'(dep1), 64'd0);
    check_eq("t6_rst_valid", 64'(exc0.valid), 64'd0);

    // Random traffic against the model.
    for (int it = 0; it < 3000; it++) begin
      call_heavy = ((it / 400) % 2) == 0;
      en     = ($urandom_range(0, 9) != 0);
      clr    = ($urandom_range(0, 59) == 0);
      rst    = ($urandom_range(0, 249) == 0);
      ex_ack = ($urandom_range(0, 3) == 0);
      for (int p = 0; p < NR; p++) begin
        if ($urandom_range(0, 2) != 0) begin
          kind = $urandom_range(0, 9);
          rr = {$urandom(), $urandom()};
          pc[p] = ($urandom_range(0, 31) == 0) ? '1 : rr[VLEN-1:0];
          is_comp[p] = $urandom_range(0, 1) == 1;
          ack[p] = 1'b1;
          is_call[p] = call_heavy ? (kind <= 5) : (kind <= 2 || kind == 8);
          is_ret[p]  = call_heavy ? (kind >= 6 && kind <= 8) : (kind >= 3 && kind <= 8);
          if (p == 1 && ack[0] && is_call[0])
            pred = pc[0] + (is_comp[0] ? VLEN'(2) : VLEN'(4));
          else if (p == 1 && ack[0] && is_ret[0] && m_cnt[1] > 1)
            pred = m_stk[1][m_cnt[1]-2];
          else if (m_cnt[1] > 0)
            pred = m_stk[1][m_cnt[1]-1];
          else
            pred = rr[VLEN+1:2];
          tgt[p] = ($urandom_range(0, 3) != 0) ? pred : rr[VLEN+1:2];
        end
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
